// File: rtl/cyclic_encoder_stream.sv
// Serial-LFSR systematic cyclic encoder: one message bit per clock, codeword = {message, parity}.
// Define CYCLIC_ENC_CHECK_EN to add a CHECK pass that re-divides the codeword and flags a nonzero syndrome on chk_err.
module cyclic_encoder_stream #(
    parameter  int N = 15,
    parameter  int K = 5,
    localparam int M = N - K
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [K-1:0] data_in,
    input  logic [M-1:0] g,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] code_out,
    output logic         busy
`ifdef CYCLIC_ENC_CHECK_EN
    ,
    output logic         chk_err
`endif
);

`ifdef CYCLIC_ENC_CHECK_EN
    localparam int CNT_W = $clog2(N + 1);
`else
    localparam int CNT_W = $clog2(K + 1);
`endif

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
`ifdef CYCLIC_ENC_CHECK_EN
        ,
        CHECK
`endif
    } state_t;

    state_t             state_q, state_d;
    logic [K-1:0]       msg_q, msg_d;
    logic [K-1:0]       sh_q, sh_d;
    logic [M-1:0]       g_q, g_d;
    logic [M-1:0]       par_q, par_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               fb;
`ifdef CYCLIC_ENC_CHECK_EN
    logic [M-1:0]       syn_q, syn_d;
    logic               chk_q, chk_d;
    logic               chk_bit;
    logic               chk_fb;
    logic [N-1:0]       code_w;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            msg_q   <= '0;
            sh_q    <= '0;
            g_q     <= '0;
            par_q   <= '0;
            cnt_q   <= '0;
`ifdef CYCLIC_ENC_CHECK_EN
            syn_q   <= '0;
            chk_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            msg_q   <= msg_d;
            sh_q    <= sh_d;
            g_q     <= g_d;
            par_q   <= par_d;
            cnt_q   <= cnt_d;
`ifdef CYCLIC_ENC_CHECK_EN
            syn_q   <= syn_d;
            chk_q   <= chk_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        msg_d   = msg_q;
        sh_d    = sh_q;
        g_d     = g_q;
        par_d   = par_q;
        cnt_d   = cnt_q;
        fb      = sh_q[K-1] ^ par_q[M-1];
`ifdef CYCLIC_ENC_CHECK_EN
        syn_d   = syn_q;
        chk_d   = chk_q;
        code_w  = {msg_q, par_q};
        chk_bit = 1'b0;
        // Counter-indexed mux keeps the check reading the live parity register.
        for (int i = 0; i < N; i++) begin
            if (cnt_q == CNT_W'(N - 1 - i)) chk_bit = code_w[i];
        end
        chk_fb  = chk_bit ^ syn_q[M-1];
`endif
        case (state_q)
            IDLE: begin
`ifdef CYCLIC_ENC_CHECK_EN
                chk_d = 1'b0;
`endif
                if (in_valid) begin
                    msg_d   = data_in;
                    sh_d    = data_in;
                    g_d     = g;
                    par_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                par_d = (par_q << 1) ^ (fb ? g_q : '0);
                sh_d  = sh_q << 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(K - 1)) begin
                    cnt_d   = '0;
`ifdef CYCLIC_ENC_CHECK_EN
                    syn_d   = '0;
                    state_d = CHECK;
`else
                    state_d = DONE;
`endif
                end
            end
`ifdef CYCLIC_ENC_CHECK_EN
            CHECK: begin
                syn_d = (syn_q << 1) ^ (chk_fb ? g_q : '0);
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(N - 1)) begin
                    cnt_d   = '0;
                    chk_d   = (syn_d != '0);
                    state_d = DONE;
                end
            end
`endif
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
`ifdef CYCLIC_ENC_CHECK_EN
                    chk_d   = 1'b0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign code_out  = out_valid ? {msg_q, par_q} : '0;
`ifdef CYCLIC_ENC_CHECK_EN
    assign chk_err   = chk_q;
`endif

endmodule

// File: tb/tb_cyclic_encoder_stream.sv
// Directed plus random bench for cyclic_encoder_stream; parity reference is polynomial long division.
// Latency is counted in edges from the accept edge inclusive to the first edge after which out_valid is seen.
module tb_cyclic_encoder_stream;

    localparam int N = 15;
    localparam int K = 5;
    localparam int M = N - K;
`ifdef CYCLIC_ENC_CHECK_EN
    localparam int EXP_LAT = K + N + 1;
`else
    localparam int EXP_LAT = K + 1;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [K-1:0] data_in = '0;
    logic [M-1:0] g = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] code_out;
    logic         busy;
`ifdef CYCLIC_ENC_CHECK_EN
    logic         chk_err;
`endif

    int total = 0;
    int bad   = 0;

    cyclic_encoder_stream #(.N(N), .K(K)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .g         (g),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .code_out  (code_out),
        .busy      (busy)
`ifdef CYCLIC_ENC_CHECK_EN
        ,
        .chk_err   (chk_err)
`endif
    );

    always #5 clk = ~clk;

    // x^M * m(x) mod g(x), by schoolbook long division over GF(2).
    function automatic logic [M-1:0] ref_par(input logic [K-1:0] m, input logic [M-1:0] gg);
        logic [63:0] r;
        logic [63:0] gf;
        r  = 64'(m) << M;
        gf = (64'(1) << M) | 64'(gg);
        for (int i = N - 1; i >= M; i--) begin
            if (r[i]) r = r ^ (gf << (i - M));
        end
        return r[M-1:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one word, scramble inputs every cycle until out_valid, check result and handshake.
    task automatic encode(input logic [K-1:0] d, input logic [M-1:0] gg, input int hold);
        logic [N-1:0] exp_cw;
        int lat;
        exp_cw = {d, ref_par(d, gg)};
        chk("in_ready_before_accept", 64'(in_ready), 64'(1));
        in_valid  = 1'b1;
        data_in   = d;
        g         = gg;
        out_ready = (hold == 0);
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            data_in = K'($urandom);
            g       = M'($urandom);
            tick();
            lat++;
        end
        chk("latency", 64'(lat), 64'(EXP_LAT));
        chk("code_out", 64'(code_out), 64'(exp_cw));
`ifdef CYCLIC_ENC_CHECK_EN
        chk("chk_err_clean", 64'(chk_err), 64'(0));
`endif
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                tick();
                chk("bp_out_valid", 64'(out_valid), 64'(1));
                chk("bp_code_out", 64'(code_out), 64'(exp_cw));
                chk("bp_in_ready", 64'(in_ready), 64'(0));
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end else begin
            tick();
        end
        chk("after_out_valid", 64'(out_valid), 64'(0));
        chk("after_in_ready", 64'(in_ready), 64'(1));
    endtask

    initial begin
        logic [M-1:0] gr;
        logic [K-1:0] dr;

        repeat (2) tick();
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_code_out", 64'(code_out), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
`ifdef CYCLIC_ENC_CHECK_EN
        chk("rst_chk_err", 64'(chk_err), 64'(0));
`endif
        reset = 1'b0;
        tick();

        // Known vectors against g(x) = x^10+x^8+x^5+x^4+x^2+x+1.
        chk("ref_0537", 64'({5'b00001, ref_par(5'b00001, 10'h137)}), 64'(15'h0537));
        encode(5'b00001, 10'h137, 0);
        encode(5'b00010, 10'h137, 0);
        chk("ref_0A6E", 64'({5'b00010, ref_par(5'b00010, 10'h137)}), 64'(15'h0A6E));
        encode(5'b00011, 10'h137, 0);
        encode(5'b00000, 10'h137, 0);
        encode(5'b10110, 10'h137, 10);

        // Reset during the third shift cycle discards the word.
        in_valid = 1'b1;
        data_in  = 5'b10101;
        g        = 10'h137;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("midrst_out_valid", 64'(out_valid), 64'(0));
        chk("midrst_code_out", 64'(code_out), 64'(0));
        chk("midrst_in_ready", 64'(in_ready), 64'(1));
        chk("midrst_busy", 64'(busy), 64'(0));
        reset = 1'b0;
        encode(5'b00001, 10'h137, 0);

        for (int n = 0; n < 25; n++) begin
            gr = M'($urandom) | M'(1);
            dr = K'($urandom);
            encode(dr, gr, int'($urandom_range(0, 3)));
        end

`ifdef CYCLIC_ENC_CHECK_EN
        // Corrupt parity bit 0 during CHECK; the syndrome must become nonzero.
        in_valid = 1'b1;
        data_in  = 5'b00001;
        g        = 10'h137;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        repeat (K) tick();
        force dut.par_q = 10'h137 ^ 10'h001;
        for (int i = 0; i < 100 && !out_valid; i++) tick();
        chk("fault_out_valid", 64'(out_valid), 64'(1));
        chk("fault_chk_err", 64'(chk_err), 64'(1));
        release dut.par_q;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("fault_rst_chk_err", 64'(chk_err), 64'(0));
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
